// File: rtl/npu_result_drain_if.sv
// ============================================================================
// Module   : npu_result_drain_if
// Purpose  : Valid/ready result stream from the NPU result drain stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface npu_result_drain_if #(
   parameter int OUT_W = 16
);
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [3:0]       out_idx;
   logic             out_sat;
   logic             out_last;

   modport master (
      output out_valid, out_data, out_idx, out_sat, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_idx, out_sat, out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/npu_result_drain.sv
// ============================================================================
// Module   : npu_result_drain
// Purpose  : Snapshots the 3x3 accumulator tile on done, then streams the nine
//            ReLU/saturated results out in row-major order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npu_result_drain #(
   parameter int DATA_W  = 32,
   parameter int OUT_W   = 16,
   parameter int RELU_EN = 1
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     done,
   input  wire logic signed [DATA_W-1:0] c1,
   input  wire logic signed [DATA_W-1:0] c2,
   input  wire logic signed [DATA_W-1:0] c3,
   input  wire logic signed [DATA_W-1:0] c4,
   input  wire logic signed [DATA_W-1:0] c5,
   input  wire logic signed [DATA_W-1:0] c6,
   input  wire logic signed [DATA_W-1:0] c7,
   input  wire logic signed [DATA_W-1:0] c8,
   input  wire logic signed [DATA_W-1:0] c9,
   input  wire logic                     ovr_clr,
   output logic                          busy,
   output logic                          drain_done,
   output logic                          overrun,
   npu_result_drain_if.master            out_if
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam logic [3:0] c_last_idx = 4'd8;
   localparam logic signed [DATA_W-1:0] c_max_val =
      {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] c_min_val =
      {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t                    r_state;
   logic [3:0]                r_idx;
   logic signed [DATA_W-1:0]  r_snap [0:8];
   logic                      r_drain_done;
   logic                      r_overrun;

   logic signed [DATA_W-1:0]  w_cur;
   logic signed [DATA_W-1:0]  w_val;
   logic [OUT_W-1:0]          w_res;
   logic                      w_sat;
   logic                      w_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= 4'd0;
         r_drain_done <= 1'b0;
         r_overrun    <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            r_snap[i] <= '0;
         end
      end else begin
         r_drain_done <= 1'b0;
         // A tile completing while we still drain is dropped; set beats clear.
         if (done && (r_state == ST_DRAIN)) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr) begin
            r_overrun <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (done) begin
                  r_snap[0] <= c1;
                  r_snap[1] <= c2;
                  r_snap[2] <= c3;
                  r_snap[3] <= c4;
                  r_snap[4] <= c5;
                  r_snap[5] <= c6;
                  r_snap[6] <= c7;
                  r_snap[7] <= c8;
                  r_snap[8] <= c9;
                  r_idx     <= 4'd0;
                  r_state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (out_if.out_ready) begin
                  if (r_idx == c_last_idx) begin
                     r_idx        <= 4'd0;
                     r_drain_done <= 1'b1;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_cur   = r_snap[r_idx];
   assign w_valid = (r_state == ST_DRAIN);

   always_comb begin
      w_val = w_cur;
      w_sat = 1'b0;
      if ((RELU_EN != 0) && (w_cur < 0)) begin
         w_val = '0;
      end
      w_res = w_val[OUT_W-1:0];
      if (w_val > c_max_val) begin
         w_res = c_max_val[OUT_W-1:0];
         w_sat = 1'b1;
      end else if (w_val < c_min_val) begin
         w_res = c_min_val[OUT_W-1:0];
         w_sat = 1'b1;
      end
   end

   assign out_if.out_valid = w_valid;
   assign out_if.out_data  = w_valid ? w_res : '0;
   assign out_if.out_idx   = r_idx;
   assign out_if.out_sat   = w_valid & w_sat;
   assign out_if.out_last  = w_valid & (r_idx == c_last_idx);
   assign busy             = w_valid;
   assign drain_done       = r_drain_done;
   assign overrun          = r_overrun;

endmodule

`default_nettype wire
